// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings
// and a constant-evaluable ceiling-log2 used to size the counters.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ARM_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_ARM_RELEASE = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((longint'(1) << r) < longint'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous board inputs.
// Both stages clear to 0 on reset so a held input is seen as a fresh edge.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronised input, stability-counted FSM, and
// registered level plus one-cycle press/release/long-hold pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = 500000,
  parameter int HOLD_CNT   = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  localparam int CW = clog2(STABLE_CNT);
  localparam int HW = clog2(HOLD_CNT) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CNT);

  logic btn_s;

  state_t          state_d, state_q;
  logic [CW-1:0]   cnt_d, cnt_q;
  logic [HW-1:0]   hcnt_d, hcnt_q;
  logic            level_d, level_q;
  logic            press_d, press_q;
  logic            release_d, release_q;
  logic            hold_d, hold_q;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        level_d = 1'b0;
        if (btn_s) begin
          state_d = ST_ARM_PRESS;
          cnt_d   = CW'(1);
        end
      end

      ST_ARM_PRESS: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          hcnt_d  = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_PRESSED: begin
        // Saturating one past the fire value keeps the pulse to once per press.
        if (hcnt_q != HOLD_SAT) begin
          hcnt_d = hcnt_q + HW'(1);
        end
        if (hcnt_q == HOLD_LAST) begin
          hold_d = 1'b1;
        end
        if (!btn_s) begin
          state_d = ST_ARM_RELEASE;
          cnt_d   = CW'(1);
        end
      end

      ST_ARM_RELEASE: begin
        if (btn_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign hold_pulse    = hold_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (STABLE_CNT=4, HOLD_CNT=16): expected pulse
// events are queued with their cycle number and checked by a monitor.
module tb_btn_debounce;

  localparam int STABLE = 4;
  localparam int HOLD   = 16;
  localparam int LAT    = STABLE + 2;   // drive cycle -> pulse visible cycle

  localparam int K_PRESS   = 1;
  localparam int K_RELEASE = 2;
  localparam int K_HOLD    = 3;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic btn_level, press_pulse, release_pulse, hold_pulse;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  sb_q[$];

  btn_debounce #(.STABLE_CNT(STABLE), .HOLD_CNT(HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .hold_pulse    (hold_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    sb_q.push_back(e);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    int   kind;
    ev_t  e;
    if (press_pulse || release_pulse || hold_pulse) begin
      chk("pulse_exclusive", int'(press_pulse) + int'(release_pulse) + int'(hold_pulse), 1);
      kind = press_pulse ? K_PRESS : (release_pulse ? K_RELEASE : K_HOLD);
      $display("event kind=%0d at cycle %0d level=%0d", kind, cyc, btn_level);
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse_kind", kind, 0);
      end else begin
        e = sb_q.pop_front();
        chk("ev_kind", kind, e.kind);
        chk("ev_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Press at current cycle, release after hold_len cycles; hold fires if long enough.
  task automatic press_release(input string tag, input int hold_len);
    int c;
    c = cyc;
    btn_in = 1'b1;
    push(c + LAT, K_PRESS);
    if (hold_len - 3 >= HOLD) push(c + LAT + HOLD, K_HOLD);
    wait_to(c + LAT - 1);
    chk({tag, "_level_pre"}, btn_level, 0);
    wait_to(c + LAT);
    chk({tag, "_level_on"}, btn_level, 1);
    wait_to(c + hold_len);
    btn_in = 1'b0;
    push(c + hold_len + LAT, K_RELEASE);
    wait_to(c + hold_len + LAT - 1);
    chk({tag, "_level_hold"}, btn_level, 1);
    wait_to(c + hold_len + LAT);
    chk({tag, "_level_off"}, btn_level, 0);
    wait_to(c + hold_len + LAT + 8);
  endtask

  initial begin
    int c, c2;
    logic [6:0] bounce;

    // Reset asserted with the button already down.
    rst_n  = 1'b1;
    btn_in = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outs_immediate", {btn_level, press_pulse, release_pulse, hold_pulse}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs_held", {btn_level, press_pulse, release_pulse, hold_pulse}, 0);

    // Reset released with button held: full press latency, then hold and release.
    c = cyc;
    rst_n = 1'b1;
    push(c + LAT, K_PRESS);
    push(c + LAT + HOLD, K_HOLD);
    wait_to(c + LAT - 1);
    chk("rstrel_level_pre", btn_level, 0);
    wait_to(c + LAT);
    chk("rstrel_level_on", btn_level, 1);
    wait_to(c + 30);
    btn_in = 1'b0;
    push(c + 30 + LAT, K_RELEASE);
    wait_to(c + 30 + LAT);
    chk("rstrel_level_off", btn_level, 0);
    wait_to(c + 30 + LAT + 8);

    // Clean press/release of 30 cycles.
    press_release("clean", 30);

    // Bounce: runs shorter than STABLE never change the level.
    bounce = 7'b0111011;   // applied LSB first: 1,1,0,1,1,1,0
    for (int i = 0; i < 7; i++) begin
      btn_in = bounce[i];
      @(posedge clk);
      #1;
      chk("bounce_level", btn_level, 0);
    end
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("bounce_level_after", btn_level, 0);
    end

    // Release glitch: 2-cycle low dip freezes hcnt for 2 cycles.
    c = cyc;
    btn_in = 1'b1;
    push(c + LAT, K_PRESS);
    push(c + LAT + HOLD + 2, K_HOLD);
    wait_to(c + 10);
    btn_in = 1'b0;
    wait_to(c + 12);
    btn_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("glitch_level", btn_level, 1);
    end
    wait_to(c + 40);
    btn_in = 1'b0;
    push(c + 40 + LAT, K_RELEASE);
    wait_to(c + 40 + LAT);
    chk("glitch_level_off", btn_level, 0);
    wait_to(c + 40 + LAT + 8);

    // Long hold: exactly one hold pulse in 100 cycles.
    press_release("long", 100);

    // Reset mid ARM_PRESS with cnt=3: no press, full restart required.
    c = cyc;
    btn_in = 1'b1;
    wait_to(c + LAT - 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {btn_level, press_pulse, release_pulse, hold_pulse}, 0);
    repeat (2) @(posedge clk);
    #1;
    c2 = cyc;
    rst_n = 1'b1;
    push(c2 + LAT, K_PRESS);
    push(c2 + LAT + HOLD, K_HOLD);
    wait_to(c2 + LAT - 1);
    chk("midrst_level_pre", btn_level, 0);
    wait_to(c2 + LAT);
    chk("midrst_level_on", btn_level, 1);

    // Reset while pressed: level clears at once, no release pulse.
    wait_to(c2 + 25);
    rst_n = 1'b0;
    #1;
    chk("pressed_rst_level", btn_level, 0);
    btn_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("pressed_rst_level_after", btn_level, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input conditioner for a raw push-button. Turns the user input into clean, single-cycle control events, complementing the LED output path that signals to the user. It synchronises the asynchronous pin, filters contact bounce with a stability counter, and emits a debounced level plus one-cycle press, release and long-hold pulses. It sits between the board button pin and any control FSM in the same `clk` domain.

## Interface
- `STABLE_CNT`, default 500000 (10 ms at 50 MHz): consecutive synchronised cycles required to accept a level change. Must be ≥ 2.
- `HOLD_CNT`, default 50000000 (1 s): cycles in PRESSED before `hold_pulse` fires. Must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_in`  in  1  raw button, asynchronous to `clk`, active high.
- `btn_level`  out  1  debounced button state; registered.
- `press_pulse`  out  1  one-cycle pulse on accepted press.
- `release_pulse`  out  1  one-cycle pulse on accepted release.
- `hold_pulse`  out  1  one-cycle pulse once per press after `HOLD_CNT` cycles held.

## Operation
- `btn_in` passes through a 2-flop synchroniser. Its output is `btn_s`. The FSM uses only `btn_s`.
- `cnt` is the stability counter, width clog2(`STABLE_CNT`). `hcnt` is the hold counter, width clog2(`HOLD_CNT`)+1.
- State IDLE (`btn_level`=0):
  - `btn_s`=1 → ARM_PRESS, `cnt`←1.
- State ARM_PRESS:
  - `btn_s`=0 → IDLE, `cnt`←0. This is a glitch and produces no pulse.
  - `btn_s`=1 and `cnt`==`STABLE_CNT`−1 → PRESSED, with `btn_level`←1, `press_pulse`←1, `hcnt`←0.
  - Otherwise `cnt`++.
- State PRESSED (`btn_level`=1):
  - `hcnt` increments each cycle and saturates.
  - When `hcnt`==`HOLD_CNT`−1, `hold_pulse`←1. This happens exactly once per press.
  - `btn_s`=0 → ARM_RELEASE, `cnt`←1.
- State ARM_RELEASE (`btn_level` stays 1, `hcnt` frozen):
  - `btn_s`=1 → PRESSED, `cnt`←0. This is a glitch: no pulse, and `hcnt` resumes from its frozen value.
  - `btn_s`=0 and `cnt`==`STABLE_CNT`−1 → IDLE, with `btn_level`←0 and `release_pulse`←1.
  - Otherwise `cnt`++.
- Pulses are registered, high for exactly one cycle, and mutually exclusive.
- No counter ever wraps. `cnt` resets on every state change, and `hcnt` saturates.

## Timing
- Reset (`rst_n`=0): state IDLE, synchroniser flops 0, `cnt`=`hcnt`=0, and all four outputs 0, all immediately (asynchronous).
- Press latency: if `btn_in` is high and stable from sampling edge k, then `btn_level` and `press_pulse` go high after edge k+`STABLE_CNT`+1. `press_pulse` drops after the next edge.
- Release latency is symmetric: stable low from edge k → `btn_level`=0 and `release_pulse`=1 after edge k+`STABLE_CNT`+1.
- Hold: on entering PRESSED at edge p with no release glitches, `hold_pulse` is high after edge p+`HOLD_CNT`.
- Bounce shorter than `STABLE_CNT` cycles never changes `btn_level`.
- Reset mid-operation: outputs clear at once. If the button is still held after `rst_n` rises, a fresh press is detected after full latency, and no release pulse is emitted.
- A `btn_in` change on the same edge that completes a count does not affect that transition. It is seen 2 cycles later via `btn_s`.

## Structure
- Shared package/include `btn_pkg`: 2-bit state encodings (IDLE=0, ARM_PRESS=1, PRESSED=2, ARM_RELEASE=3) and a clog2 helper function.
- Sub-module `sync_2ff`: 1-bit, two-flop synchroniser with async active-low reset to 0, reusable for other board inputs.
- Top-level `btn_debounce` holds the FSM, both counters and the output registers.

## Test plan
All directed tests use `STABLE_CNT`=4 and `HOLD_CNT`=16.
- Reset: assert `rst_n`=0 with `btn_in`=1 → all outputs 0 immediately and throughout. Release reset with `btn_in` held → `press_pulse` after edge k+5 from first sample.
- Clean press/release: `btn_in` high 30 cycles then low → `press_pulse` 1 cycle at k+5, `btn_level` high, `release_pulse` 1 cycle 5 edges after low sampled, `hold_pulse` at p+16.
- Bounce rejection: toggle `btn_in` 1,1,0,1,1,1,0 (runs < 4) then low → `btn_level` stays 0, no pulses.
- Release glitch: press held, single 2-cycle low dip → no `release_pulse`, `btn_level` stays 1, `hold_pulse` delayed by the frozen cycles and fires once.
- Long hold: hold 100 cycles → exactly one `hold_pulse`, and `hcnt` saturates without a second pulse.
- Reset mid-press: `rst_n` low during ARM_PRESS at `cnt`=3 → no `press_pulse`, and a restart requires a full 4 stable cycles.
